// File: rtl/roller_pkg.sv
// Shared helpers for the roller_flex lane serialiser. They size the beat counter
// and build the lane-valid mask of the final beat.
package roller_pkg;

  // Upper bound on output lanes per beat that pad_mask can describe.
  localparam int MAX_LANES = 64;

  function automatic int ceil_div(int a, int b);
    return (a + b - 1) / b;
  endfunction

  // Beat index width; never narrower than one bit, even when a vector is a single beat.
  function automatic int idx_width(int cycles);
    int w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

  // Lane mask of the final beat. Pad lanes sit at the top in forward order and
  // at the bottom in reverse order.
  function automatic logic [MAX_LANES-1:0] pad_mask(int roll, int pad, bit reverse);
    logic [MAX_LANES-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (i < roll) begin
        m[i] = reverse ? (i >= pad) : (i < roll - pad);
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/roller_flex_if.sv
// Stream bundle around roller_flex. Input side: one NUM-lane vector per handshake.
// Output side: ROLL_NUM-lane beats with mask, index and last flag.
interface roller_flex_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM        = 8,
  parameter int ROLL_NUM   = 3
);
  localparam int IDX_W = roller_pkg::idx_width(roller_pkg::ceil_div(NUM, ROLL_NUM));

  // Handshake rule on both sides: a transfer happens on a rising clk edge where
  // valid and ready are both high; the sender holds valid and the payload stable until then.
  logic [DATA_WIDTH-1:0] data_in [NUM];
  logic                  data_in_valid;
  logic                  data_in_ready;
  logic [DATA_WIDTH-1:0] data_out [ROLL_NUM];
  logic [ROLL_NUM-1:0]   data_out_mask;
  logic [IDX_W-1:0]      data_out_idx;
  logic                  data_out_last;
  logic                  data_out_valid;
  logic                  data_out_ready;

  modport master (
    input  data_in, data_in_valid, data_out_ready,
    output data_in_ready, data_out, data_out_mask, data_out_idx,
           data_out_last, data_out_valid
  );

  modport slave (
    output data_in, data_in_valid, data_out_ready,
    input  data_in_ready, data_out, data_out_mask, data_out_idx,
           data_out_last, data_out_valid
  );

endinterface

// File: rtl/roller_flex.sv
// Serialises a NUM-lane vector into ceil(NUM/ROLL_NUM) beats of ROLL_NUM lanes.
// The final beat is zero-padded and masked. A new vector loads on the last beat with no bubble.
module roller_flex
  import roller_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM        = 8,
  parameter int ROLL_NUM   = 3,
  parameter int REVERSE    = 0
) (
  input  logic          clk,
  input  logic          rst,
  roller_flex_if.master bus
);

  localparam int CYCLES = ceil_div(NUM, ROLL_NUM);
  localparam int PAD    = CYCLES * ROLL_NUM - NUM;
  localparam int CW     = $clog2(CYCLES + 1);
  localparam int IW     = idx_width(CYCLES);
  localparam int TOTAL  = CYCLES * ROLL_NUM;
  localparam int SRW    = TOTAL * DATA_WIDTH;

  localparam logic [MAX_LANES-1:0] LAST_MASK_FULL = pad_mask(ROLL_NUM, PAD, REVERSE != 0);
  localparam logic [ROLL_NUM-1:0]  LAST_MASK      = LAST_MASK_FULL[ROLL_NUM-1:0];

  if (ROLL_NUM < 1) begin : g_bad_roll_lo
    $error("roller_flex: ROLL_NUM must be at least 1");
  end
  if (ROLL_NUM > NUM) begin : g_bad_roll_hi
    $error("roller_flex: ROLL_NUM must not exceed NUM");
  end
  if (DATA_WIDTH < 1) begin : g_bad_width
    $error("roller_flex: DATA_WIDTH must be at least 1");
  end

  logic [CW-1:0]  count;     // beats still to be emitted for the held vector
  logic [IW-1:0]  idx;
  logic [SRW-1:0] sr;        // lane 0 of the current beat sits in the low bits
  logic [SRW-1:0] load_vec;
  logic           out_valid;
  logic           out_last;
  logic           out_fire;
  logic           load;

  assign out_valid = (count != '0);
  assign out_last  = (count == CW'(1));
  assign out_fire  = out_valid & bus.data_out_ready;

  // Ready on the last beat as well, so the next vector replaces it in the same edge.
  assign bus.data_in_ready = (count == '0) | (out_last & bus.data_out_ready);
  assign load              = bus.data_in_valid & bus.data_in_ready;

  // Shift-register position p is lane K of beat B; REVERSE walks beats from the top of data_in.
  for (genvar p = 0; p < TOTAL; p++) begin : g_load
    localparam int B   = p / ROLL_NUM;
    localparam int K   = p % ROLL_NUM;
    localparam int SRC = (REVERSE != 0) ? NUM - 1 - (B * ROLL_NUM + (ROLL_NUM - 1 - K)) : p;
    if (SRC >= 0 && SRC < NUM) begin : g_data
      assign load_vec[p*DATA_WIDTH +: DATA_WIDTH] = bus.data_in[SRC];
    end else begin : g_pad
      assign load_vec[p*DATA_WIDTH +: DATA_WIDTH] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      idx   <= '0;
      sr    <= '0;
    end else if (load) begin
      sr    <= load_vec;
      count <= CW'(CYCLES);
      idx   <= '0;
    end else if (out_fire) begin
      sr    <= sr >> (ROLL_NUM * DATA_WIDTH);
      count <= count - CW'(1);
      // Return idx to zero after the final beat so an idle port shows all-zero outputs.
      idx   <= out_last ? '0 : idx + IW'(1);
    end
  end

  for (genvar k = 0; k < ROLL_NUM; k++) begin : g_out
    assign bus.data_out[k] = sr[k*DATA_WIDTH +: DATA_WIDTH];
  end

  assign bus.data_out_valid = out_valid;
  assign bus.data_out_last  = out_last;
  assign bus.data_out_idx   = idx;
  assign bus.data_out_mask  = !out_valid ? '0 : (out_last ? LAST_MASK : '1);

endmodule
